// File: rtl/led_seq_ctrl.sv
// ---------------------------------------------------------------------------
// led_seq_ctrl
//   Run-time sequencer for the board's four LEDs. A prescaler generates step
//   ticks, and a three-state FSM (IDLE/RUN/PAUSE) steps one of four patterns
//   for LAPS full cycles before it signals completion and returns to IDLE.
//
// Parameters
//   TICK_CYCLES  clk cycles per pattern step (>= 2)
//   LAPS         full 4-step cycles before auto-stop, 0 = run until stopped
//
// Ports
//   clk     in   system clock
//   rst     in   synchronous reset, active-high
//   start   in   one-cycle pulse, begin sequence (mode latched here)
//   stop    in   one-cycle pulse, abort to IDLE
//   pause   in   one-cycle pulse, toggle RUN/PAUSE
//   mode    in   [1:0] pattern: 0 chase, 1 fill, 2 reverse chase, 3 blink
//   speed   in   [1:0] step period divider TICK_CYCLES >> speed
//                (present only when LED_SEQ_SPEED_EN is defined)
//   led     out  [3:0] registered LED drive, 1 = on
//   busy    out  high while not IDLE
//   done    out  one-cycle pulse when the lap limit is reached
//   step    out  [1:0] current step index
//
// Build option
//   LED_SEQ_SPEED_EN  adds the speed port; undefined, the step period is
//                     always TICK_CYCLES.
//
// state   | meaning
// S_IDLE  | LEDs off, prescaler cleared, waiting for start
// S_RUN   | prescaler counting, pattern advancing on each tick
// S_PAUSE | prescaler, step, lap and LEDs frozen until the next pause pulse
// ---------------------------------------------------------------------------
module led_seq_ctrl #(
  parameter int unsigned TICK_CYCLES = 12_000_000,
  parameter int unsigned LAPS        = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       pause,
  input  logic [1:0] mode,
`ifdef LED_SEQ_SPEED_EN
  input  logic [1:0] speed,
`endif
  output logic [3:0] led,
  output logic       busy,
  output logic       done,
  output logic [1:0] step
);

  localparam int PW = $clog2(TICK_CYCLES);
  localparam int LW = (LAPS < 2) ? 1 : $clog2(LAPS + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2
  } state_t;

  state_t          r_state;
  logic [PW-1:0]   r_presc;
  logic [1:0]      r_step;
  logic [LW-1:0]   r_lap;
  logic [1:0]      r_mode;
  logic [3:0]      r_led;
  logic            r_busy;
  logic            r_done;

  logic [PW-1:0]   w_tc;
  logic            w_tick;
  logic [1:0]      w_step_nxt;
  logic [LW-1:0]   w_lap_nxt;
  logic            w_lap_hit;

  function automatic logic [3:0] f_pattern(input logic [1:0] m, input logic [1:0] s);
    logic [3:0] p;
    p = 4'b0000;
    case (m)
      2'd0: p = 4'b0001 << s;
      2'd1: begin
        case (s)
          2'd0:    p = 4'b0001;
          2'd1:    p = 4'b0011;
          2'd2:    p = 4'b0111;
          default: p = 4'b1111;
        endcase
      end
      2'd2: p = 4'b1000 >> s;
      default: p = s[0] ? 4'b0000 : 4'b1111;
    endcase
    return p;
  endfunction

`ifdef LED_SEQ_SPEED_EN
  logic [1:0]  r_speed;
  logic [31:0] w_period;

  // Divided period never drops below two cycles so the prescaler still wraps.
  always_comb begin
    w_period = 32'(TICK_CYCLES) >> r_speed;
    if (w_period < 32'd2) w_period = 32'd2;
    w_tc = PW'(w_period - 32'd1);
  end
`else
  assign w_tc = PW'(TICK_CYCLES - 1);
`endif

  always_comb begin
    w_tick     = (r_presc == w_tc);
    w_step_nxt = r_step + 2'd1;
    w_lap_nxt  = r_lap + LW'(1);
    // Lap limit is only reachable on the 3->0 wrap; LAPS == 0 never stops.
    w_lap_hit  = (LAPS != 0) && (r_step == 2'd3) && (w_lap_nxt == LW'(LAPS));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_presc <= '0;
      r_step  <= '0;
      r_lap   <= '0;
      r_mode  <= '0;
      r_led   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef LED_SEQ_SPEED_EN
      r_speed <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_presc <= '0;
          r_led   <= '0;
          // stop outranks start, so a coincident pair leaves us idle.
          if (start && !stop) begin
            r_state <= S_RUN;
            r_busy  <= 1'b1;
            r_step  <= 2'd0;
            r_lap   <= '0;
            r_mode  <= mode;
            r_led   <= f_pattern(mode, 2'd0);
`ifdef LED_SEQ_SPEED_EN
            r_speed <= speed;
`endif
          end
        end

        S_RUN: begin
          if (stop) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_presc <= '0;
            r_step  <= '0;
            r_lap   <= '0;
            r_led   <= '0;
          end else if (w_tick) begin
            r_presc <= '0;
            if (w_lap_hit) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_step  <= '0;
              r_lap   <= '0;
              r_led   <= '0;
            end else begin
              r_step <= w_step_nxt;
              r_led  <= f_pattern(r_mode, w_step_nxt);
              if (r_step == 2'd3) r_lap <= w_lap_nxt;
              // The step still advances on a coincident tick; pause then freezes it.
              if (pause) r_state <= S_PAUSE;
            end
          end else begin
            // The pause edge itself still counts, so resuming neither loses
            // nor repeats a cycle of the current step.
            r_presc <= r_presc + PW'(1);
            if (pause) r_state <= S_PAUSE;
          end
        end

        S_PAUSE: begin
          if (stop) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_presc <= '0;
            r_step  <= '0;
            r_lap   <= '0;
            r_led   <= '0;
          end else if (pause) begin
            r_state <= S_RUN;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_led   <= '0;
        end
      endcase
    end
  end

  assign led  = r_led;
  assign busy = r_busy;
  assign done = r_done;
  assign step = r_step;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Directed bench for led_seq_ctrl: TICK_CYCLES=4 with LAPS=2 (dut) and
// LAPS=0 (dut0).
module tb_led_seq_ctrl;

  logic       clk;
  logic       rst;
  logic       start, stop, pause;
  logic [1:0] mode;
  logic [3:0] led;
  logic       busy, done;
  logic [1:0] step;

  logic       start0, stop0, pause0;
  logic [1:0] mode0;
  logic [3:0] led0;
  logic       busy0, done0;
  logic [1:0] step0;

`ifdef LED_SEQ_SPEED_EN
  logic [1:0] speed, speed0;
`endif

  int n_chk;
  int n_fail;

  logic [3:0] chase_tbl [4];
  logic [3:0] fill_tbl  [4];

  led_seq_ctrl #(.TICK_CYCLES(4), .LAPS(2)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .stop  (stop),
    .pause (pause),
    .mode  (mode),
`ifdef LED_SEQ_SPEED_EN
    .speed (speed),
`endif
    .led   (led),
    .busy  (busy),
    .done  (done),
    .step  (step)
  );

  led_seq_ctrl #(.TICK_CYCLES(4), .LAPS(0)) dut0 (
    .clk   (clk),
    .rst   (rst),
    .start (start0),
    .stop  (stop0),
    .pause (pause0),
    .mode  (mode0),
`ifdef LED_SEQ_SPEED_EN
    .speed (speed0),
`endif
    .led   (led0),
    .busy  (busy0),
    .done  (done0),
    .step  (step0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic saw_done;
    n_chk  = 0;
    n_fail = 0;
    chase_tbl = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    fill_tbl  = '{4'b0001, 4'b0011, 4'b0111, 4'b1111};

    rst = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0; mode = 2'd0;
    start0 = 1'b0; stop0 = 1'b0; pause0 = 1'b0; mode0 = 2'd0;
`ifdef LED_SEQ_SPEED_EN
    speed = 2'd0; speed0 = 2'd0;
`endif

    // 1. reset
    cyc(2);
    check("rst_led",  int'(led),  0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_step", int'(step), 0);
    rst = 1'b0;
    cyc(1);

    // 2. chase, two laps, 4 cycles per step
    mode = 2'd0; start = 1'b1;
    cyc(1);
    start = 1'b0;
    check("start_busy", int'(busy), 1);
    for (int i = 0; i < 32; i++) begin
      check("chase_led", int'(led), int'(chase_tbl[(i / 4) % 4]));
      check("chase_done_low", int'(done), 0);
      cyc(1);
    end
    check("chase_done", int'(done), 1);
    check("chase_end_led", int'(led), 0);
    check("chase_end_busy", int'(busy), 0);
    check("chase_end_step", int'(step), 0);
    cyc(1);
    check("chase_done_pulse", int'(done), 0);

    // 3. fill, mode change while busy ignored
    mode = 2'd1; start = 1'b1;
    cyc(1);
    start = 1'b0;
    for (int s = 0; s < 5; s++) begin
      check("fill_led", int'(led), int'(fill_tbl[s % 4]));
      if (s == 1) mode = 2'd3;
      cyc(4);
    end
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
    check("fill_stop_led", int'(led), 0);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    for (int s = 0; s < 4; s++) begin
      check("blink_led", int'(led), (s % 2 == 0) ? 15 : 0);
      cyc(3);
      check("blink_hold", int'(led), (s % 2 == 0) ? 15 : 0);
      cyc(1);
    end
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;

    // 4. pause at step 2 / prescaler 1, resume, pause on tick
    mode = 2'd0; start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(9);
    check("pre_pause_step", int'(step), 2);
    pause = 1'b1;
    cyc(1);
    pause = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check("pause_led", int'(led), 4);
      check("pause_step", int'(step), 2);
      cyc(1);
    end
    check("pause_busy", int'(busy), 1);
    pause = 1'b1;
    cyc(1);
    pause = 1'b0;
    check("resume_led0", int'(led), 4);
    cyc(1);
    check("resume_led1", int'(led), 4);
    cyc(1);
    check("resume_step3", int'(step), 3);
    check("resume_led3", int'(led), 8);
    cyc(3);
    pause = 1'b1;
    cyc(1);
    pause = 1'b0;
    check("tickpause_step", int'(step), 0);
    check("tickpause_led", int'(led), 1);
    cyc(5);
    check("tickpause_hold_step", int'(step), 0);
    check("tickpause_hold_led", int'(led), 1);
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
    check("pstop_led", int'(led), 0);
    check("pstop_busy", int'(busy), 0);
    check("pstop_done", int'(done), 0);

    // 5. stop at step 1, start+stop in idle, start while running
    mode = 2'd0; start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(4);
    check("s1_step", int'(step), 1);
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
    check("stop_led", int'(led), 0);
    check("stop_busy", int'(busy), 0);
    saw_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (done) saw_done = 1'b1;
      cyc(1);
    end
    check("stop_no_done", int'(saw_done), 0);
    start = 1'b1; stop = 1'b1;
    cyc(1);
    start = 1'b0; stop = 1'b0;
    check("ss_busy", int'(busy), 0);
    check("ss_led", int'(led), 0);
    cyc(1);
    check("ss_busy2", int'(busy), 0);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(5);
    mode = 2'd2; start = 1'b1;
    cyc(1);
    start = 1'b0;
    check("restart_step", int'(step), 1);
    check("restart_led", int'(led), 2);
    cyc(2);
    check("restart_step2", int'(step), 2);
    check("restart_led2", int'(led), 4);
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;

    // reverse chase, then reset mid-run
    mode = 2'd2; start = 1'b1;
    cyc(1);
    start = 1'b0;
    check("rev_led0", int'(led), 8);
    cyc(4);
    check("rev_led1", int'(led), 4);
    cyc(4);
    check("rev_led2", int'(led), 2);
    cyc(4);
    check("rev_led3", int'(led), 1);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    check("midrst_led", int'(led), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_step", int'(step), 0);
    check("midrst_done", int'(done), 0);

    // 6. LAPS=0: 100 ticks, no done
    mode0 = 2'd0; start0 = 1'b1;
    cyc(1);
    start0 = 1'b0;
    saw_done = 1'b0;
    for (int t = 0; t < 100; t++) begin
      check("free_step", int'(step0), t % 4);
      repeat (4) begin
        cyc(1);
        if (done0) saw_done = 1'b1;
      end
    end
    check("free_step_end", int'(step0), 0);
    check("free_busy", int'(busy0), 1);
    check("free_no_done", int'(saw_done), 0);
    stop0 = 1'b1;
    cyc(1);
    stop0 = 1'b0;
    check("free_stop_busy", int'(busy0), 0);

`ifdef LED_SEQ_SPEED_EN
    speed0 = 2'd1; start0 = 1'b1;
    cyc(1);
    start0 = 1'b0;
    speed0 = 2'd0;
    check("spd_step0", int'(step0), 0);
    cyc(1);
    check("spd_step0b", int'(step0), 0);
    cyc(1);
    check("spd_step1", int'(step0), 1);
    cyc(2);
    check("spd_step2", int'(step0), 2);
    stop0 = 1'b1;
    cyc(1);
    stop0 = 1'b0;
    speed0 = 2'd3; start0 = 1'b1;
    cyc(1);
    start0 = 1'b0;
    cyc(2);
    check("spd_min_step1", int'(step0), 1);
    stop0 = 1'b1;
    cyc(1);
    stop0 = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/led_seq_ctrl.md
Name: led_seq_ctrl

Overview:
- Run-time sequencer for the board's 4 LEDs. It replaces a free-running compare counter with a controlled pattern engine.
- A prescaler produces step ticks. A 3-state FSM (IDLE/RUN/PAUSE) steps one of four selectable patterns for a programmed number of laps, then signals completion.
- Sits between push-button/command logic and the LED pins.

Parameters:
- TICK_CYCLES, 12_000_000: clk cycles per pattern step (1 s at 12 MHz). Must be ≥2.
- LAPS, 3: full 4-step pattern cycles before auto-stop. 0 = run until stopped.

Ports:
- clk  input  1  system clock (12 MHz PCLK)
- rst  input  1  synchronous reset, active-high
- start  input  1  one-cycle pulse; begin sequence
- stop  input  1  one-cycle pulse; abort to IDLE
- pause  input  1  one-cycle pulse; toggle RUN/PAUSE
- mode  input  2  pattern select, sampled on accepted start
- led  output  4  registered LED drive, 1 = on
- busy  output  1  high when state ≠ IDLE
- done  output  1  one-cycle pulse on lap-limit completion
- step  output  2  current step index 0..3

Behaviour:
- Reset: clk and rst only; reset is synchronous and active-high. State = IDLE; led=0000, busy=0, done=0, step=0; prescaler, lap counter and latched mode = 0.
- Patterns, by latched mode and step s:
  - 0 chase: 0001 << s
  - 1 fill: 0001, 0011, 0111, 1111
  - 2 reverse chase: 1000 >> s
  - 3 blink: s even = 1111, s odd = 0000
- IDLE:
  - led=0000, prescaler held at 0.
  - An accepted start at edge k moves to RUN at edge k, with step=0, lap=0, mode latched and led=pattern(step 0). led is therefore visible the cycle after the start pulse.
  - pause is ignored in IDLE.
- RUN:
  - The prescaler counts 0..TICK_CYCLES-1 and wraps.
  - tick is asserted when prescaler == TICK_CYCLES-1. On that edge step advances mod 4 and led updates in the same edge. Every step lasts exactly TICK_CYCLES cycles.
  - Step wrap 3→0 increments lap.
  - If LAPS≠0 and the incremented lap == LAPS: go to IDLE on that edge, led=0000, done=1 for one cycle, step=0.
- PAUSE:
  - Prescaler, step, lap and led all hold.
  - A pause pulse returns to RUN, continuing from the held prescaler value. No count is lost or repeated.
- Priority (highest first): rst > stop > tick/auto-stop > pause > start.
  - stop in RUN/PAUSE: IDLE next edge, led=0000, no done.
  - stop and start together in IDLE: remain in IDLE.
  - tick and pause in the same cycle: the step advances, then the FSM enters PAUSE.
  - start while busy: ignored; mode is not re-latched.
  - mode changes while busy: ignored.
  - Reset mid-run: returns immediately to reset values, no done.
- Widths:
  - Prescaler is $clog2(TICK_CYCLES) bits.
  - Lap counter is wide enough for LAPS; minimum 1 bit.

Optional Feature:
- Macro: LED_SEQ_SPEED_EN
- Defined:
  - Adds port speed, input, 2 bits, sampled with mode on accepted start.
  - Step period = TICK_CYCLES >> speed (÷1, ÷2, ÷4, ÷8), minimum 2 cycles.
  - A speed change while busy is ignored.
- Undefined: port absent; step period is always TICK_CYCLES.

Test Plan:
All scenarios use TICK_CYCLES=4, LAPS=2 unless stated.
1. Reset: assert rst for 2 cycles → led=0000, busy=0, done=0, step=0. Then start → led=0001 and busy=1 on the next cycle.
2. Chase, mode=0: start → led 0001, 0010, 0100, 1000, each held exactly 4 cycles, two laps. After 32 cycles: done high for 1 cycle, led=0000, busy=0.
3. Fill, mode=1: led 0001→0011→0111→1111→0001. Apply mode=3 mid-run → pattern unchanged. Then restart with mode=3 → 1111/0000 alternating every 4 cycles.
4. Pause at step=2 with prescaler=1: led holds 0100 for 10 cycles. A second pause resumes and step 3 appears exactly 3 cycles later. Pause in the same cycle as a tick → step advances, then holds.
5. stop at step=1 → next cycle led=0000, busy=0, done never asserted. start and stop together in IDLE → stays IDLE. start while RUN → no restart.
6. LAPS=0: 100 ticks with no done, step wrapping 3→0. With LED_SEQ_SPEED_EN and speed=1 → step period is 2 cycles.
